debug_mem_dumper: RTL and testbench
===================================

# debug_mem_dumper

Debug-side initiator for the data memory's debug read port. On a dump request it asserts debug mode, walks every data-memory word from address 0 to DEPTH-1, captures each word from the debug data port and serialises it MSB-byte-first to the debug UART transmitter through a start/done handshake. It sits between the debug unit's command decoder and the UART TX, and is the only driver of the memory's debug enable and debug address.

## Interface
- DEPTH, 32, number of data-memory words dumped (addresses 0..DEPTH-1)
- ADDR_W, 32, width of debug address port
- DATA_W, 32, memory word width; fixed multiple of 8 (4 bytes at default)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- dump_start  in  1  one-cycle request to begin a full dump; ignored while busy
- dump_abort  in  1  cancel an in-progress dump; priority over everything except rst
- dbg_on  out  1  debug enable to memory; high from first REQ until dump ends
- dbg_addr  out  ADDR_W  word address presented to memory debug read port
- dbg_data  in  DATA_W  word returned by memory debug read port
- tx_start  out  1  one-cycle pulse: tx_data valid, transmitter must send it
- tx_data  out  8  byte to transmit; held stable until next tx_start
- tx_done  in  1  one-cycle pulse from transmitter: byte fully sent
- busy  out  1  high in every state except IDLE
- dump_done  out  1  one-cycle pulse when the last byte of address DEPTH-1 is acknowledged

## Operation
- States: IDLE, REQ, WAIT, SEND, WAIT_TX, DONE.
- IDLE: dbg_on=0. dump_start=1 -> REQ, dbg_addr=0, byte_cnt=0.
- REQ: dbg_on=1, dbg_addr driven; memory samples on its falling edge. -> WAIT.
- WAIT: on leaving edge, word register <= dbg_data. -> SEND.
- SEND: tx_start=1, tx_data=word[DATA_W-1-8*byte_cnt -: 8] (byte 0 = bits 31:24). -> WAIT_TX.
- WAIT_TX: hold. tx_done=1 -> if byte_cnt<3: byte_cnt++, -> SEND; else if dbg_addr==DEPTH-1 -> DONE; else dbg_addr++, byte_cnt=0, -> REQ.
- DONE: dump_done=1, dbg_on=0, dbg_addr=0. -> IDLE.
- dump_abort=1 in any non-IDLE state: next state IDLE, dbg_on=0, dbg_addr=0, byte_cnt=0, tx_start=0; dump_done not pulsed. A byte already handed to the transmitter completes there; its tx_done is ignored.
- dump_start and dump_abort in same cycle in IDLE: abort wins, stay IDLE.
- tx_done outside WAIT_TX is ignored (no counter change).
- dbg_addr never exceeds DEPTH-1; no wrap to 0 mid-dump.
- dbg_on stays high across REQ/WAIT/SEND/WAIT_TX of all words (CPU stays in debug mode for the whole dump).

## Timing
- Reset values: dbg_on=0, dbg_addr=0, tx_start=0, tx_data=0, busy=0, dump_done=0; state IDLE, byte_cnt=0.
- dump_start at edge N -> dbg_on=1, busy=1 from cycle N+1.
- First tx_start at cycle N+3 (REQ, WAIT, SEND).
- Per byte: SEND 1 cycle + WAIT_TX ≥1 cycle. With tx_done returned the cycle after tx_start: 2 cycles/byte, 10 cycles/word, total 10*DEPTH+1 cycles from dump_start to dump_done.
- dump_done asserted exactly one cycle, the cycle after the final tx_done; busy high in that cycle, low the next.
- Mid-operation rst: identical to reset values on the next edge.

## Structure
- Shared debug package: state encoding constants, BYTES_PER_WORD=DATA_W/8, byte-index width.
- Single module; FSM, address counter, byte counter and word register in one file. No sub-module required.

## Test plan
- Memory preloaded word i = 0x00000000 except word 20 = 0x00000AAA; dump_start, transmitter acks 1 cycle after each tx_start -> 128 bytes, bytes 80..83 = 0x00,0x00,0x0A,0xAA, dump_done at cycle 321 after start.
- Word 0 = 0x11223344, transmitter acks after 5 cycles -> tx_data sequence 0x11,0x22,0x33,0x44, tx_data stable between pulses, dbg_addr stays 0 throughout.
- dump_abort during WAIT_TX of address 7 byte 2 -> next cycle IDLE, dbg_on=0, busy=0, no dump_done; late tx_done ignored; new dump_start restarts at address 0.
- dump_start pulsed while busy, and stray tx_done in SEND/REQ -> no effect on address, byte count or output sequence.
- rst asserted mid-dump at address 12 -> all outputs at reset values next cycle; state IDLE.
- DEPTH=4 parameter override -> exactly 16 tx_start pulses, dbg_addr max 3, dump_done once.

Source files
------------

// File: rtl/debug_mem_dumper_pkg.sv
// Shared definitions for the debug memory dump path: FSM encoding and
// byte-lane helpers used to serialise memory words to the debug UART.
package debug_mem_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int DATA_W_DEFAULT = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / BYTE_W;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Byte index needs at least one bit even for single-byte words.
  function automatic int byte_idx_w(input int data_w);
    return (data_w / BYTE_W > 1) ? $clog2(data_w / BYTE_W) : 1;
  endfunction

endpackage

// File: rtl/debug_mem_dumper.sv
// Walks the whole data memory through its debug read port and streams each
// word MSB-byte-first to the debug UART transmitter.
module debug_mem_dumper
  import debug_mem_dumper_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_abort,
  output logic              dbg_on,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              dump_done
);

  localparam int                BPW       = bytes_per_word(DATA_W);
  localparam int                BIW       = byte_idx_w(DATA_W);
  localparam logic [BIW-1:0]    LAST_BYTE = BIW'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [BIW-1:0]    byte_cnt;
  logic [DATA_W-1:0] word_sh;

  always_ff @(posedge clk) begin
    tx_start  <= 1'b0;
    dump_done <= 1'b0;
    if (rst) begin
      state    <= ST_IDLE;
      dbg_on   <= 1'b0;
      dbg_addr <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else if (dump_abort && state != ST_IDLE) begin
      // An in-flight byte finishes in the transmitter; its ack lands in IDLE.
      state    <= ST_IDLE;
      dbg_on   <= 1'b0;
      dbg_addr <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (dump_start && !dump_abort) begin
            state    <= ST_REQ;
            dbg_on   <= 1'b1;
            busy     <= 1'b1;
            dbg_addr <= '0;
            byte_cnt <= '0;
          end
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          // Capture the word and launch its top byte on the same edge.
          word_sh  <= dbg_data << BYTE_W;
          tx_data  <= dbg_data[DATA_W-1 -: 8];
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_done) begin
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
              tx_data  <= word_sh[DATA_W-1 -: 8];
              word_sh  <= word_sh << BYTE_W;
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end else if (dbg_addr == LAST_ADDR) begin
              state     <= ST_DONE;
              dump_done <= 1'b1;
              dbg_on    <= 1'b0;
              dbg_addr  <= '0;
              byte_cnt  <= '0;
            end else begin
              dbg_addr <= dbg_addr + 1'b1;
              byte_cnt <= '0;
              state    <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          dbg_on <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Directed bench for debug_mem_dumper: scoreboarded byte stream, handshake
// timing, abort/reset behaviour and a reduced-depth instance.
module tb_debug_mem_dumper;

  logic        clk = 1'b0;
  logic        rst, dump_start, dump_abort, tx_done;
  logic [31:0] dbg_data;
  logic        dbg_on, tx_start, busy, dump_done;
  logic [31:0] dbg_addr;
  logic [7:0]  tx_data;

  logic        dump_start4, dump_abort4, tx_done4;
  logic [31:0] dbg_data4;
  logic        dbg_on4, tx_start4, busy4, dump_done4;
  logic [31:0] dbg_addr4;
  logic [7:0]  tx_data4;

  debug_mem_dumper #(.DEPTH(32), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .dump_abort(dump_abort),
    .dbg_on(dbg_on), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .dump_done(dump_done)
  );

  debug_mem_dumper #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .dump_start(dump_start4), .dump_abort(dump_abort4),
    .dbg_on(dbg_on4), .dbg_addr(dbg_addr4), .dbg_data(dbg_data4),
    .tx_start(tx_start4), .tx_data(tx_data4), .tx_done(tx_done4),
    .busy(busy4), .dump_done(dump_done4)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [7:0]  q[$];
  logic [7:0]  q4[$];

  int total = 0, bad = 0;
  int cyc = 0, c0 = 0, ack_dly = 1, pend = 0, pend4 = 0;
  int tx_pulses = 0, done_cnt = 0, done_cyc = 0, t_base = 0;
  int pulses4 = 0, done4 = 0, max_addr4 = 0;
  bit stray_en = 0, chk_stable = 0, post_done = 0, prev_on = 0, req_seen;
  logic [31:0] prev_addr = '0;
  logic [7:0]  last_byte = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs on the falling edge, then play memory and transmitter.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (post_done) begin
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", dump_done, 0);
      post_done = 0;
    end
    if (tx_start) begin
      if (q.size() == 0) chk("txq_empty", 1, 0);
      else chk("tx_byte", tx_data, q.pop_front());
      chk("addr_bound", dbg_addr < 32, 1);
      tx_pulses++;
      last_byte = tx_data;
    end else if (chk_stable && busy && tx_pulses != t_base) begin
      chk("tx_hold", tx_data, last_byte);
    end
    if (dump_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_in_done", busy, 1);
      chk("dbg_on_in_done", dbg_on, 0);
      post_done = 1;
    end
    dbg_data = mem[dbg_addr[4:0]];
    req_seen = dbg_on && (!prev_on || dbg_addr != prev_addr);
    tx_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) tx_done = 1'b1;
    end
    if (tx_start) pend = ack_dly;
    if (stray_en && (tx_start || req_seen)) tx_done = 1'b1;
    prev_on = dbg_on;
    prev_addr = dbg_addr;

    if (tx_start4) begin
      if (q4.size() == 0) chk("txq4_empty", 1, 0);
      else chk("tx4_byte", tx_data4, q4.pop_front());
      pulses4++;
      if (int'(dbg_addr4) > max_addr4) max_addr4 = int'(dbg_addr4);
    end
    if (dump_done4) done4++;
    dbg_data4 = 32'hA0B0C0D0 + dbg_addr4;
    tx_done4 = 1'b0;
    if (pend4 > 0) begin
      pend4--;
      if (pend4 == 0) tx_done4 = 1'b1;
    end
    if (tx_start4) pend4 = 1;
  endtask

  task automatic start_dump();
    logic [31:0] wv;
    for (int w = 0; w < 32; w++) begin
      wv = mem[w];
      for (int b = 0; b < 4; b++) q.push_back(wv[31-8*b -: 8]);
    end
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
  endtask

  initial begin
    int n, p0, d0;
    logic [31:0] wv;
    rst = 1'b1; dump_start = 0; dump_abort = 0; tx_done = 0; dbg_data = '0;
    dump_start4 = 0; dump_abort4 = 0; tx_done4 = 0; dbg_data4 = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[20] = 32'h0000_0AAA;
    repeat (2) tick();
    chk("rst_dbg_on", dbg_on, 0);
    chk("rst_dbg_addr", dbg_addr, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dump_done", dump_done, 0);
    rst = 1'b0;
    tick();

    // Full dump, one-cycle acks
    t_base = tx_pulses;
    start_dump();
    chk("start_dbg_on", dbg_on, 1);
    chk("start_busy", busy, 1);
    tick();
    chk("tx_not_yet", tx_start, 0);
    tick();
    chk("first_tx_start", tx_start, 1);
    wait_done(2000);
    chk("dump_cycles", done_cyc - c0 + 1, 321);
    chk("byte_count", tx_pulses - t_base, 128);
    chk("queue_drained", q.size(), 0);
    tick();

    // Slow transmitter, word 0 = 0x11223344
    mem[0] = 32'h1122_3344;
    ack_dly = 5;
    chk_stable = 1;
    t_base = tx_pulses;
    start_dump();
    n = 0;
    while (tx_pulses < t_base + 4 && n < 100) begin
      tick();
      chk("addr_word0", dbg_addr, 0);
      n++;
    end
    wait_done(3000);
    chk_stable = 0;
    tick();

    // Abort during WAIT_TX of address 7, byte 2
    ack_dly = 3;
    t_base = tx_pulses;
    start_dump();
    n = 0;
    while (tx_pulses < t_base + 31 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reach", tx_pulses - t_base, 31);
    tick();
    chk("abort_addr", dbg_addr, 7);
    dump_abort = 1'b1;
    tick();
    dump_abort = 1'b0;
    chk("abort_dbg_on", dbg_on, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr0", dbg_addr, 0);
    chk("abort_tx_start", tx_start, 0);
    q.delete();
    p0 = tx_pulses;
    d0 = done_cnt;
    repeat (8) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_tx", tx_pulses, p0);
    chk("abort_idle", busy, 0);
    ack_dly = 1;
    start_dump();
    chk("restart_addr", dbg_addr, 0);
    wait_done(2000);
    chk("restart_cycles", done_cyc - c0 + 1, 321);
    tick();

    // Abort beats start in IDLE
    dump_start = 1'b1;
    dump_abort = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_abort = 1'b0;
    chk("abort_wins_busy", busy, 0);
    chk("abort_wins_on", dbg_on, 0);
    tick();

    // Stray acks in SEND/REQ plus a start pulse while busy
    ack_dly = 2;
    stray_en = 1;
    start_dump();
    repeat (50) tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_done(2000);
    chk("stray_cycles", done_cyc - c0 + 1, 449);
    chk("stray_queue", q.size(), 0);
    stray_en = 0;
    ack_dly = 1;
    tick();

    // Reset mid-dump at address 12
    start_dump();
    n = 0;
    while (dbg_addr != 12 && n < 500) begin
      tick();
      n++;
    end
    chk("reach_addr12", dbg_addr, 12);
    rst = 1'b1;
    tick();
    chk("mrst_dbg_on", dbg_on, 0);
    chk("mrst_dbg_addr", dbg_addr, 0);
    chk("mrst_tx_start", tx_start, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dump_done", dump_done, 0);
    rst = 1'b0;
    q.delete();
    repeat (4) tick();
    chk("mrst_stays_idle", busy, 0);

    // Reduced-depth instance
    for (int w = 0; w < 4; w++) begin
      wv = 32'hA0B0C0D0 + w;
      for (int b = 0; b < 4; b++) q4.push_back(wv[31-8*b -: 8]);
    end
    dump_start4 = 1'b1;
    tick();
    dump_start4 = 1'b0;
    n = 0;
    while (done4 == 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("d4_pulses", pulses4, 16);
    chk("d4_max_addr", max_addr4, 3);
    chk("d4_done_once", done4, 1);
    chk("d4_queue", q4.size(), 0);
    chk("d4_idle", busy4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
